// File: rtl/spi_slave_regif.sv
// spi_slave_regif: SPI mode-0 slave decoding 40-bit frames into register write/read strobes.
module spi_slave_regif #(
    parameter int ADDR_W     = 7,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [31:0]       reg_rdata,
    output logic              busy,
    output logic              frame_err
);
    typedef enum logic [2:0] {IDLE, CMD, RD_WAIT, DATA, DONE} state_t;
    state_t      state, state_nx;
    logic [1:0]  sclk_s, ss_s, mosi_s;
    logic        sclk_d, ss_d, is_rd;
    logic [5:0]  bit_cnt;
    logic [31:0] rx, tx;
    logic [1:0]  lat_cnt;
    logic        rise, fall, ss_fall, ss_rise, in_frame, shifting, last_cmd, last_data, lat_done;
    logic [7:0]  cmd_byte;

    assign rise      = sclk_s[1] & ~sclk_d;
    assign fall      = ~sclk_s[1] & sclk_d;
    assign ss_fall   = ~ss_s[1] & ss_d;
    assign ss_rise   = ss_s[1] & ~ss_d;
    assign cmd_byte  = {rx[6:0], mosi_s[1]};
    assign in_frame  = state == CMD || state == RD_WAIT || state == DATA;
    assign shifting  = (state == CMD || state == DATA) && rise;
    // ss_n rising wins over a coincident final sclk edge
    assign last_cmd  = state == CMD && rise && bit_cnt == 6'd7 && !ss_rise;
    assign last_data = state == DATA && rise && bit_cnt == 6'd39 && !ss_rise;
    assign lat_done  = state == RD_WAIT && lat_cnt == 2'(RD_LATENCY);
    assign busy      = state != IDLE;

    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = (state != IDLE && ss_rise) ? IDLE :
                   (state == IDLE && ss_fall) ? CMD :
                   last_cmd ? (cmd_byte[7] ? RD_WAIT : DATA) :
                   lat_done ? DATA :
                   last_data ? DONE : state;
    end

    // Sync flops reset to 0 so a low ss_n at reset release is not seen as a new frame start
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_s    <= '0;
            ss_s      <= '0;
            mosi_s    <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            is_rd     <= 1'b0;
            lat_cnt   <= '0;
            spi_miso  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sclk_s    <= {sclk_s[0], spi_sclk};
            ss_s      <= {ss_s[0], spi_ss_n};
            mosi_s    <= {mosi_s[0], spi_mosi};
            sclk_d    <= sclk_s[1];
            ss_d      <= ss_s[1];
            reg_wr    <= last_data && !is_rd;
            reg_rd    <= last_cmd && cmd_byte[7];
            frame_err <= in_frame && ss_rise;
            lat_cnt   <= state == RD_WAIT ? lat_cnt + 2'd1 : 2'd0;
            if (state == IDLE && ss_fall)
                bit_cnt <= '0;
            else if (shifting && bit_cnt != 6'd40)
                bit_cnt <= bit_cnt + 6'd1;
            if (shifting)
                rx <= {rx[30:0], mosi_s[1]};
            if (last_cmd) begin
                reg_addr <= cmd_byte[ADDR_W-1:0];
                is_rd    <= cmd_byte[7];
            end
            if (last_data && !is_rd)
                reg_wdata <= {rx[30:0], mosi_s[1]};
            // Bit 31 stays on MISO through the fall after the 8th rise; shifting starts after the 9th
            if (ss_rise)
                spi_miso <= 1'b0;
            else if (lat_done) begin
                tx       <= reg_rdata;
                spi_miso <= reg_rdata[31];
            end else if (state == DATA && is_rd && fall && bit_cnt > 6'd8) begin
                tx       <= {tx[30:0], 1'b0};
                spi_miso <= tx[30];
            end
        end
    end
endmodule
